// File: rtl/router_pkg.sv
// Shared router definitions: default word/packet geometry and the scheduler state encoding.
package router_pkg;
  localparam int DATA_W    = 64;
  localparam int PKT_WORDS = 16;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from last_g+1, wrapping.
module rr_arbiter #(
  parameter int  NUM_IN = 4,
  localparam int LW     = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [LW-1:0]     last_g,
  output logic [NUM_IN-1:0] pick,
  output logic              any
);
  import router_pkg::*;

  int            sum;
  logic [LW-1:0] idx;

  // Walk from the farthest candidate down so the nearest one after last_g wins.
  always_comb begin
    pick = '0;
    sum  = 0;
    idx  = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      sum = int'(last_g) + k;
      if (sum >= NUM_IN) sum = sum - NUM_IN;
      idx = LW'(sum);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/output_port_0_sched.sv
// Round-robin scheduler for output port 0: grants one input per packet, forwards its words,
// and tracks free packet slots in the output queue as credits.
module output_port_0_sched #(
  parameter int  NUM_IN     = 4,
  parameter int  DATA_W     = router_pkg::DATA_W,
  parameter int  PKT_WORDS  = router_pkg::PKT_WORDS,
  parameter int  QUEUE_PKTS = 2,
  localparam int LW         = $clog2(NUM_IN),
  localparam int WCW        = $clog2(PKT_WORDS),
  localparam int CW         = $clog2(QUEUE_PKTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req_in,
  input  logic [NUM_IN-1:0]        valid_in,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic                     done_decap_pkt,
  output logic [NUM_IN-1:0]        grant_out,
  output logic [DATA_W-1:0]        data_out_port_0,
  output logic                     we_output_port_0,
  output logic [CW-1:0]            credits,
  output logic                     credit_err
);
  import router_pkg::*;

  sched_state_t                    state, state_nxt;
  logic [NUM_IN-1:0]               pick;
  logic                            any;
  logic [LW-1:0]                   pick_idx, g_idx, last_g;
  logic [WCW-1:0]                  word_cnt;
  logic                            start, v, last_word, done_ok;
  logic [NUM_IN-1:0][DATA_W-1:0]   din_w;

  assign din_w = data_in;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req    (req_in),
    .last_g (last_g),
    .pick   (pick),
    .any    (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (pick[i]) pick_idx = LW'(i);
  end

  assign start     = (state == IDLE) && any && (credits != '0);
  assign v         = (state == XFER) && valid_in[g_idx];
  assign last_word = v && (word_cnt == WCW'(PKT_WORDS - 1));
  assign done_ok   = done_decap_pkt && (credits != CW'(QUEUE_PKTS));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = XFER;
      XFER:    if (last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, packet position and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_out <= '0;
      g_idx     <= '0;
      last_g    <= LW'(NUM_IN - 1);
      word_cnt  <= '0;
    end else if (start) begin
      grant_out <= pick;
      g_idx     <= pick_idx;
      word_cnt  <= '0;
    end else if (v) begin
      if (last_word) begin
        grant_out <= '0;
        last_g    <= g_idx;
        word_cnt  <= '0;
      end else begin
        word_cnt  <= word_cnt + WCW'(1);
      end
    end
  end

  // Data path: bubbles drop the write enable and hold the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_port_0  <= '0;
      we_output_port_0 <= 1'b0;
    end else begin
      we_output_port_0 <= v;
      if (v) data_out_port_0 <= din_w[g_idx];
    end
  end

  // A grant and a returned credit in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= CW'(QUEUE_PKTS);
      credit_err <= 1'b0;
    end else begin
      if (start && !done_ok)      credits <= credits - CW'(1);
      else if (done_ok && !start) credits <= credits + CW'(1);
      if (done_decap_pkt && (credits == CW'(QUEUE_PKTS))) credit_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_output_port_0_sched.sv
// Directed bench for output_port_0_sched: reset, single packet, round-robin, credit stall,
// bubbles, credit overflow and mid-packet reset.
module tb_output_port_0_sched;
  localparam int NI = 4;
  localparam int DW = 64;
  localparam int PW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NI-1:0]   req_in, valid_in;
  logic [NI*DW-1:0] data_in;
  logic            done_decap_pkt;
  logic [NI-1:0]   grant_out;
  logic [DW-1:0]   data_out_port_0;
  logic            we_output_port_0;
  logic [1:0]      credits;
  logic            credit_err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] exp_dout;

  always #5 clk = ~clk;

  output_port_0_sched #(.NUM_IN(NI), .DATA_W(DW), .PKT_WORDS(PW), .QUEUE_PKTS(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_in           (req_in),
    .valid_in         (valid_in),
    .data_in          (data_in),
    .done_decap_pkt   (done_decap_pkt),
    .grant_out        (grant_out),
    .data_out_port_0  (data_out_port_0),
    .we_output_port_0 (we_output_port_0),
    .credits          (credits),
    .credit_err       (credit_err)
  );

  function automatic logic [DW-1:0] word(input int i, input int w);
    return {8'(i + 1), 24'h0, 32'h11110000 + 32'(w)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_words(input int w);
    for (int i = 0; i < NI; i++) data_in[i*DW +: DW] = word(i, w);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_in = '0; valid_in = '0; data_in = '0; done_decap_pkt = 1'b0;
    step();
    rst = 1'b0;
    exp_dout = '0;
  endtask

  // Waits for the grant, then streams one packet, checking every forwarded cycle.
  task automatic run_pkt(input int p, input int exp_wait, input int bub_a, input int bub_b,
                         input logic done_on_grant, input int exp_cred, input logic [NI-1:0] req_after);
    int n, wc, cyc;
    logic bub;
    logic [NI-1:0] exp_g;
    exp_g = '0; exp_g[p] = 1'b1;
    valid_in = '1; drive_words(0);
    done_decap_pkt = done_on_grant;
    n = 0;
    do begin
      step(); done_decap_pkt = 1'b0; n++;
    end while (grant_out == '0 && n < 8);
    n_chk++;
    if (grant_out !== exp_g || n != exp_wait)
      $display("FAIL grant_p%0d: got %b after %0d cycles, want %b after %0d", p, grant_out, n, exp_g, exp_wait);
    else n_pass++;
    n_chk++;
    if (credits !== 2'(exp_cred)) $display("FAIL credits_at_grant_p%0d: got %0d want %0d", p, credits, exp_cred);
    else n_pass++;
    req_in = req_after;
    wc = 0;
    for (cyc = 0; wc < PW && cyc < 40; cyc++) begin
      bub = (cyc == bub_a) || (cyc == bub_b);
      valid_in = '1;
      if (bub) valid_in[p] = 1'b0;
      drive_words(wc);
      step();
      if (!bub) begin exp_dout = word(p, wc); wc++; end
      n_chk++;
      if (we_output_port_0 !== !bub || data_out_port_0 !== exp_dout)
        $display("FAIL data_p%0d_cyc%0d: we=%b data=%h want we=%b data=%h", p, cyc, we_output_port_0,
                 data_out_port_0, !bub, exp_dout);
      else n_pass++;
      n_chk++;
      if (grant_out !== ((wc == PW) ? '0 : exp_g))
        $display("FAIL hold_grant_p%0d_cyc%0d: got %b (words %0d)", p, cyc, grant_out, wc);
      else n_pass++;
    end
    n_chk++;
    if (wc != PW) $display("FAIL pkt_len_p%0d: got %0d words want %0d", p, wc, PW);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (grant_out !== '0 || we_output_port_0 !== 1'b0 || data_out_port_0 !== '0 ||
        credits !== 2'd2 || credit_err !== 1'b0)
      $display("FAIL reset: grant=%b we=%b data=%h cred=%0d err=%b want 0 0 0 2 0",
               grant_out, we_output_port_0, data_out_port_0, credits, credit_err);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    req_in = 4'b0001;
    run_pkt(0, 1, -1, -1, 1'b0, 1, 4'b0000);
    step();
    n_chk++;
    if (grant_out !== '0 || we_output_port_0 !== 1'b0 || credits !== 2'd1)
      $display("FAIL single_after: grant=%b we=%b cred=%0d want 0 0 1", grant_out, we_output_port_0, credits);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    req_in = 4'b1111;
    run_pkt(0, 1, -1, -1, 1'b0, 1, 4'b1111);
    run_pkt(1, 1, -1, -1, 1'b1, 1, 4'b1111);
    run_pkt(2, 1, -1, -1, 1'b1, 1, 4'b1111);
    run_pkt(3, 1, -1, -1, 1'b1, 1, 4'b1111);
    run_pkt(0, 1, -1, -1, 1'b1, 1, 4'b0000);
    done_decap_pkt = 1'b1; step(); done_decap_pkt = 1'b0;
    n_chk++;
    if (credits !== 2'd2 || credit_err !== 1'b0)
      $display("FAIL rr_credit_return: cred=%0d err=%b want 2 0", credits, credit_err);
    else n_pass++;
  endtask

  task automatic test_credit_stall();
    do_reset();
    req_in = 4'b0011;
    run_pkt(0, 1, -1, -1, 1'b0, 1, 4'b0011);
    run_pkt(1, 1, -1, -1, 1'b0, 0, 4'b0011);
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (grant_out !== '0 || credits !== 2'd0)
        $display("FAIL stall_%0d: grant=%b cred=%0d want 0 0", k, grant_out, credits);
      else n_pass++;
    end
    done_decap_pkt = 1'b1; step(); done_decap_pkt = 1'b0;
    n_chk++;
    if (grant_out !== '0 || credits !== 2'd1)
      $display("FAIL stall_return: grant=%b cred=%0d want 0 1", grant_out, credits);
    else n_pass++;
    run_pkt(0, 1, -1, -1, 1'b0, 0, 4'b0000);
  endtask

  task automatic test_bubbles();
    do_reset();
    req_in = 4'b0100;
    run_pkt(2, 1, 3, 10, 1'b0, 1, 4'b0000);
  endtask

  task automatic test_credit_err();
    do_reset();
    done_decap_pkt = 1'b1; step(); done_decap_pkt = 1'b0;
    n_chk++;
    if (credits !== 2'd2 || credit_err !== 1'b1)
      $display("FAIL credit_overflow: cred=%0d err=%b want 2 1", credits, credit_err);
    else n_pass++;
    step(); step();
    n_chk++;
    if (credit_err !== 1'b1) $display("FAIL credit_err_sticky: err=%b want 1", credit_err);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    req_in = 4'b0010; valid_in = '1; drive_words(0);
    step();
    n_chk++;
    if (grant_out !== 4'b0010) $display("FAIL rst_mid_grant: got %b want 0010", grant_out);
    else n_pass++;
    for (int w = 0; w < 7; w++) begin drive_words(w); step(); end
    drive_words(7);
    rst = 1'b1; req_in = '0;
    step();
    rst = 1'b0;
    n_chk++;
    if (grant_out !== '0 || we_output_port_0 !== 1'b0 || data_out_port_0 !== '0 ||
        credits !== 2'd2 || credit_err !== 1'b0)
      $display("FAIL rst_mid_outputs: grant=%b we=%b data=%h cred=%0d err=%b",
               grant_out, we_output_port_0, data_out_port_0, credits, credit_err);
    else n_pass++;
    req_in = 4'b1000;
    step();
    n_chk++;
    if (grant_out !== 4'b1000) $display("FAIL rst_mid_regrant3: got %b want 1000", grant_out);
    else n_pass++;
    do_reset();
    req_in = 4'b1001;
    step();
    n_chk++;
    if (grant_out !== 4'b0001) $display("FAIL rst_prio0: got %b want 0001", grant_out);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; req_in = '0; valid_in = '0; data_in = '0; done_decap_pkt = 1'b0;
    exp_dout = '0;
    step();
    test_reset();
    test_single();
    test_round_robin();
    test_credit_stall();
    test_bubbles();
    test_credit_err();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
